regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 54 +++++
 rtl/regfile_wb_arbiter.sv | 117 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Purpose : Bundles the writeback request ports of the two requesters, the
//           pipeline hold input and the registered register-file write port
//           used by regfile_wb_arbiter.
// Params  : DATA_W - width of the write data
//           CNT_W  - width of the conflict counter
// Signals : hold                          pipeline writeback freeze
//           reqN_valid/addr/data/ready    requester N handshake (N = 0 ALU, 1 load)
//           reg_write/waddr/wdata         registered register-file write port
//           conflict_cnt                  saturating count of conflict cycles
// Modports: master - the pipeline side (drives requests, sees the write port)
//           slave  - the arbiter
//
// Handshake: a requester raises reqN_valid with stable addr/data; a transfer
// happens at every rising clk edge where reqN_valid and reqN_ready are both 1.
// reqN_ready is combinational and never depends on itself.
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) ();
  logic              hold;
  logic              req0_valid;
  logic [4:0]        req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [4:0]        req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              reg_write;
  logic [4:0]        waddr;
  logic [DATA_W-1:0] wdata;
  logic [CNT_W-1:0]  conflict_cnt;

  modport master (
    output hold,
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  reg_write, waddr, wdata, conflict_cnt
  );

  modport slave (
    input  hold,
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output reg_write, waddr, wdata, conflict_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Purpose : Arbitrates two writeback requesters (0 = ALU, 1 = load) onto a
//           single register-file write port with one cycle of latency.
//           Writes to register 0 are accepted but dropped. A hold input freezes
//           acceptance, the priority pointer and the conflict counter.
// Ports   : clk     - system clock, rising edge
//           arst_n  - asynchronous active-low reset
//           bus     - regfile_wb_arbiter_if.slave (requests, hold, write port,
//                     conflict counter)
// Params  : DATA_W, CNT_W - must match the connected interface instance.
// Config  : `define WB_ARB_RR_EN selects a 1-bit round-robin pointer on
//           conflicts; without it the load requester (1) always wins.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  arst_n,
  regfile_wb_arbiter_if.slave   bus
);

  logic              grant1;
  logic              ready0;
  logic              ready1;
  logic              xfer;
  logic              conflict;
  logic [4:0]        sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              reg_write_q, reg_write_d;
  logic [4:0]        waddr_q,     waddr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

`ifdef WB_ARB_RR_EN
  // 0: requester 0 wins the next conflict, 1: requester 1 wins it.
  logic              ptr_q, ptr_d;
`endif

  // Grant selection: a lone valid requester always owns the grant; on a
  // conflict the pointer (or fixed load priority) decides.
  always_comb begin
    conflict = bus.req0_valid & bus.req1_valid;
`ifdef WB_ARB_RR_EN
    grant1   = bus.req1_valid & (~bus.req0_valid | ptr_q);
`else
    grant1   = bus.req1_valid;
`endif
    // arst_n gates the readies so nothing is accepted while reset is held.
    ready0   = arst_n & ~bus.hold & bus.req0_valid & ~grant1;
    ready1   = arst_n & ~bus.hold & grant1;
    xfer     = ready0 | ready1;
    sel_addr = ready1 ? bus.req1_addr : bus.req0_addr;
    sel_data = ready1 ? bus.req1_data : bus.req0_data;
  end

  always_comb begin
    reg_write_d = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    if (xfer) begin
      // Register 0 is hard-wired: accept the request but suppress the write.
      reg_write_d = (sel_addr != 5'd0);
      waddr_d     = sel_addr;
      wdata_d     = sel_data;
    end
    if (conflict && !bus.hold && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

`ifdef WB_ARB_RR_EN
  // After any transfer the pointer favours the other requester; hold blocks
  // transfers and so freezes it implicitly.
  always_comb begin
    ptr_d = ptr_q;
    if (ready0) begin
      ptr_d = 1'b1;
    end else if (ready1) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      reg_write_q <= 1'b0;
      waddr_q     <= 5'd0;
      wdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.req0_ready   = ready0;
  assign bus.req1_ready   = ready1;
  assign bus.reg_write    = reg_write_q;
  assign bus.waddr        = waddr_q;
  assign bus.wdata        = wdata_q;
  assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Purpose : Self-checking bench for regfile_wb_arbiter. Directed scenarios and
//           randomized traffic are compared against a transaction-level model
//           (who wins, what gets written, how many conflicts) with an expected
//           write queue. Works with and without WB_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
  localparam int DW = 16;
  localparam int CW = 8;
  localparam int W  = 5 + DW;
`ifdef WB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic arst_n = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  regfile_wb_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;

  int            m_favour;  // requester that wins the next conflict (RR build)
  int            m_cnt;
  bit            m_rw;
  logic [4:0]    m_waddr;
  logic [DW-1:0] m_wdata;
  logic [W-1:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Who the specification says is accepted this cycle (-1: nobody).
  function automatic int pick(input bit v0, input bit v1, input bit h);
    if (h) return -1;
    if (v0 && v1) return RR ? m_favour : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 5'd0;
    return 5'($urandom_range(1, 31));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    arst_n         = 1'b0;
    bus.hold       = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 5'd4;
    bus.req0_data  = 16'hAAAA;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 5'd6;
    bus.req1_data  = 16'h5555;
    #1;
    check("rst_req0_ready", 32'(bus.req0_ready), 0);
    check("rst_req1_ready", 32'(bus.req1_ready), 0);
    check("rst_reg_write", 32'(bus.reg_write), 0);
    check("rst_waddr", 32'(bus.waddr), 0);
    check("rst_wdata", 32'(bus.wdata), 0);
    check("rst_cnt", 32'(bus.conflict_cnt), 0);
    m_favour = 0;
    m_cnt    = 0;
    m_rw     = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
    exp_q.delete();
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    arst_n         = 1'b1;
  endtask

  // One clock cycle: drive, check readies, advance model, check write port.
  // g is the model's winner, gd the DUT's observed winner (-1 for none).
  task automatic cycle(input bit v0, input logic [4:0] a0, input logic [DW-1:0] d0,
                       input bit v1, input logic [4:0] a1, input logic [DW-1:0] d1,
                       input bit h, output int g, output int gd);
    logic [4:0]    na;
    logic [DW-1:0] nd;
    logic [W-1:0]  e;
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    bus.req1_data  = d1;
    bus.hold       = h;
    #1;
    g  = pick(v0, v1, h);
    gd = bus.req1_ready ? 1 : (bus.req0_ready ? 0 : -1);
    check("req0_ready", 32'(bus.req0_ready), 32'(g == 0));
    check("req1_ready", 32'(bus.req1_ready), 32'(g == 1));
    if (v0 && v1 && !h && m_cnt < (1 << CW) - 1) m_cnt++;
    m_rw = 1'b0;
    if (g >= 0) begin
      na = (g == 1) ? a1 : a0;
      nd = (g == 1) ? d1 : d0;
      m_waddr = na;
      m_wdata = nd;
      if (na != 5'd0) begin
        m_rw = 1'b1;
        exp_q.push_back({na, nd});
      end
      m_favour = 1 - g;
    end
    @(posedge clk);
    #1;
    check("reg_write", 32'(bus.reg_write), 32'(m_rw));
    check("waddr", 32'(bus.waddr), 32'(m_waddr));
    check("wdata", 32'(bus.wdata), 32'(m_wdata));
    check("conflict_cnt", 32'(bus.conflict_cnt), 32'(m_cnt));
    if (bus.reg_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'({bus.waddr, bus.wdata}), 0);
      end else begin
        e = exp_q.pop_front();
        check("write_txn", 32'({bus.waddr, bus.wdata}), 32'(e));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g, gd, saved;
    bit            pv[2];
    logic [4:0]    pa[2];
    logic [DW-1:0] pd[2];
    bit h;

    #2;
    do_reset();

    // First edge after reset release: single ALU write.
    cycle(1, 5'd5, 16'h1234, 0, 5'd0, 16'h0, 0, g, gd);
    check("first_grant", 32'(gd), 0);
    check("first_reg_write", 32'(bus.reg_write), 1);
    check("first_waddr", 32'(bus.waddr), 5);
    check("first_wdata", 32'(bus.wdata), 32'h1234);

    // Four conflict cycles from a fresh pointer.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(1, 5'd3, 16'($urandom), 1, 5'd7, 16'($urandom), 0, g, gd);
      check("conflict_grant", 32'(gd), RR ? 32'(k % 2) : 32'd1);
    end
    check("conflict_cnt4", 32'(bus.conflict_cnt), 4);

    // Load write to register 0 is accepted but dropped.
    cycle(0, 5'd0, 16'h0, 1, 5'd0, 16'hFFFF, 0, g, gd);
    check("r0_ready", 32'(gd), 1);
    check("r0_reg_write", 32'(bus.reg_write), 0);

    // Hold with both valid for three cycles, then resume.
    saved = m_cnt;
    for (int k = 0; k < 3; k++) begin
      cycle(1, 5'd10, 16'h0A0A, 1, 5'd11, 16'h0B0B, 1, g, gd);
      check("hold_no_ready", 32'(gd), 32'hFFFF_FFFF);
      check("hold_reg_write", 32'(bus.reg_write), 0);
    end
    check("hold_cnt", 32'(bus.conflict_cnt), 32'(saved));
    cycle(1, 5'd10, 16'h0A0A, 1, 5'd11, 16'h0B0B, 0, g, gd);
    check("hold_resume", 32'(gd >= 0), 1);

    // Randomized traffic; requesters keep valid/addr/data until accepted.
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] && $urandom_range(0, 9) < 6) begin
          pv[i] = 1'b1;
          pa[i] = rand_addr();
          pd[i] = 16'($urandom);
        end
      end
      h = ($urandom_range(0, 4) == 0);
      cycle(pv[0], pa[0], pd[0], pv[1], pa[1], pd[1], h, g, gd);
      if (g >= 0) pv[g] = 1'b0;
    end

    // Reset pulsed right after a transfer to register 9 has been registered.
    cycle(1, 5'd9, 16'hC0DE, 0, 5'd0, 16'h0, 0, g, gd);
    check("pre_rst_write", 32'(bus.reg_write), 1);
    #1;
    do_reset();
    cycle(0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 0, g, gd);
    check("post_rst_no_write", 32'(bus.reg_write), 0);

    // Counter saturation.
    for (int k = 0; k < 300; k++) begin
      cycle(1, 5'($urandom_range(1, 31)), 16'($urandom),
            1, 5'($urandom_range(1, 31)), 16'($urandom), 0, g, gd);
    end
    check("cnt_saturated", 32'(bus.conflict_cnt), 255);

    cycle(0, 5'd0, 16'h0, 0, 5'd0, 16'h0, 0, g, gd);
    check("exp_q_drained", 32'(exp_q.size()), 0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
